// File: rtl/cdi_pkg.sv
// Shared definitions for the CD-i NVRAM save/restore logic.
//   - nvram_state_t : states of the NVRAM backup/restore controller
//   - CDI_SECTORS   : number of 512-byte sectors covering the 8 kB NVRAM
//   - CDI_SECTOR_BYTES / CDI_SECTOR_ADDR_W : sector size and byte-offset width
package cdi_pkg;

  localparam int CDI_SECTORS       = 16;
  localparam int CDI_SECTOR_BYTES  = 512;
  localparam int CDI_SECTOR_ADDR_W = $clog2(CDI_SECTOR_BYTES);

  typedef enum logic [2:0] {
    WAIT_MOUNT,
    RD_REQ,
    RD_XFER,
    READY,
    WR_REQ,
    WR_XFER
  } nvram_state_t;

endpackage

// File: rtl/nvram_backup_ctrl.sv
// NVRAM backup/restore controller.
// Restores the 8 kB NVRAM from the mounted save image sector by sector, then
// grants the CPU access. CPU writes mark the NVRAM dirty; after AUTOSAVE_IDLE
// cycles without further CPU writes, or on an OSD "save now" request, the
// whole NVRAM is written back to the image.
//
// Ports:
//   clk30, reset_n               clock, asynchronous active-low reset
//   img_mounted, img_size_nz     image mount pulse and non-empty flag
//   backup_req                   OSD save-now pulse
//   sd_rd, sd_wr, sd_lba         sector request to the HPS
//   sd_ack                       HPS transfer active for current sector
//   sd_buff_addr/dout/wr         HPS byte offset, restore byte and strobe
//   sd_buff_din                  backup byte to the HPS
//   nvram_backup_restore_adr     NVRAM port-B address
//   nvram_restore_data/write     NVRAM port-B write data and enable
//   nvram_backup_data            NVRAM port-B read data (1-cycle latency)
//   nvram_cpu_changed            pulse per CPU NVRAM write
//   nvram_allow_cpu_access       CPU may use the NVRAM
//   busy                         restore or backup in progress
//
// Sector handshake: sd_rd (restore) or sd_wr (backup) is held high in the
// request state until the HPS raises sd_ack; the rising edge of sd_ack moves
// the FSM into the transfer state, dropping the request on the next cycle.
// The HPS then moves bytes while sd_ack is high; the falling edge of sd_ack
// completes the sector. Only one of sd_rd / sd_wr is ever asserted.
module nvram_backup_ctrl
  import cdi_pkg::*;
#(
  parameter int AUTOSAVE_IDLE = 30000000,
  parameter int SECTORS       = CDI_SECTORS
) (
  input  logic        clk30,
  input  logic        reset_n,
  input  logic        img_mounted,
  input  logic        img_size_nz,
  input  logic        backup_req,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic [3:0]  sd_lba,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  input  logic [7:0]  sd_buff_dout,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din,
  output logic [12:0] nvram_backup_restore_adr,
  output logic [7:0]  nvram_restore_data,
  output logic        nvram_restore_write,
  input  logic [7:0]  nvram_backup_data,
  input  logic        nvram_cpu_changed,
  output logic        nvram_allow_cpu_access,
  output logic        busy
);

  localparam logic [24:0] IDLE_LIMIT  = 25'(AUTOSAVE_IDLE);
  localparam logic [3:0]  LAST_SECTOR = 4'(SECTORS - 1);

  nvram_state_t state, state_nxt;
  logic [3:0]   sector, sector_nxt;
  logic         sd_ack_q;
  logic         ack_rise, ack_fall;
  logic         dirty, save_pending;
  logic [24:0]  idle_cnt, idle_nxt;
  logic         xfer_active;
  logic         autosave_due;
  logic         start_backup;

  assign ack_rise    = sd_ack & ~sd_ack_q;
  assign ack_fall    = ~sd_ack & sd_ack_q;
  assign xfer_active = (state == RD_REQ) || (state == RD_XFER) ||
                       (state == WR_REQ) || (state == WR_XFER);

  // The idle counter is held at zero while a transfer runs, so a CPU write
  // made during a backup schedules the next autosave a full idle period after
  // that backup finishes rather than immediately on return to READY.
  always_comb begin
    idle_nxt = idle_cnt;
    if (nvram_cpu_changed || xfer_active) begin
      idle_nxt = '0;
    end else if (dirty && (idle_cnt != IDLE_LIMIT)) begin
      idle_nxt = idle_cnt + 25'd1;
    end
  end

  // Decided on the value the counter takes at this edge, so the write request
  // appears exactly AUTOSAVE_IDLE cycles after the last CPU write.
  assign autosave_due = dirty && (idle_nxt == IDLE_LIMIT);

  always_comb begin
    state_nxt    = state;
    sector_nxt   = sector;
    start_backup = 1'b0;
    case (state)
      WAIT_MOUNT: begin
        if (img_mounted) begin
          sector_nxt = '0;
          state_nxt  = img_size_nz ? RD_REQ : READY;
        end
      end
      RD_REQ: begin
        if (ack_rise) state_nxt = RD_XFER;
      end
      RD_XFER: begin
        if (ack_fall) begin
          if (sector == LAST_SECTOR) begin
            sector_nxt = '0;
            state_nxt  = READY;
          end else begin
            sector_nxt = sector + 4'd1;
            state_nxt  = RD_REQ;
          end
        end
      end
      READY: begin
        // A fresh non-empty image takes priority; a simultaneous save request
        // stays latched in save_pending.
        if (img_mounted && img_size_nz) begin
          sector_nxt = '0;
          state_nxt  = RD_REQ;
        end else if (backup_req || save_pending || autosave_due) begin
          sector_nxt   = '0;
          state_nxt    = WR_REQ;
          start_backup = 1'b1;
        end
      end
      WR_REQ: begin
        if (ack_rise) state_nxt = WR_XFER;
      end
      WR_XFER: begin
        if (ack_fall) begin
          if (sector == LAST_SECTOR) begin
            sector_nxt = '0;
            state_nxt  = READY;
          end else begin
            sector_nxt = sector + 4'd1;
            state_nxt  = WR_REQ;
          end
        end
      end
      default: state_nxt = WAIT_MOUNT;
    endcase
  end

  always_ff @(posedge clk30 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= WAIT_MOUNT;
      sector   <= '0;
      sd_ack_q <= 1'b0;
      idle_cnt <= '0;
    end else begin
      state    <= state_nxt;
      sector   <= sector_nxt;
      sd_ack_q <= sd_ack;
      idle_cnt <= idle_nxt;
    end
  end

  // A CPU write in the same cycle as the backup start wins, so that write is
  // covered by a later autosave.
  always_ff @(posedge clk30 or negedge reset_n) begin
    if (!reset_n) begin
      dirty <= 1'b0;
    end else if (nvram_cpu_changed) begin
      dirty <= 1'b1;
    end else if (start_backup) begin
      dirty <= 1'b0;
    end
  end

  always_ff @(posedge clk30 or negedge reset_n) begin
    if (!reset_n) begin
      save_pending <= 1'b0;
    end else if (start_backup) begin
      save_pending <= 1'b0;
    end else if (backup_req) begin
      save_pending <= 1'b1;
    end
  end

  assign sd_rd                    = (state == RD_REQ);
  assign sd_wr                    = (state == WR_REQ);
  assign sd_lba                   = sector;
  assign nvram_backup_restore_adr = {sector, sd_buff_addr[CDI_SECTOR_ADDR_W-1:0]};
  assign nvram_restore_data       = sd_buff_dout;
  assign nvram_restore_write      = (state == RD_XFER) && sd_buff_wr && sd_ack;
  // The NVRAM read latency lines up with the HPS one-cycle read latency.
  assign sd_buff_din              = nvram_backup_data;
  assign nvram_allow_cpu_access   = (state == READY) || (state == WR_REQ) ||
                                    (state == WR_XFER);
  assign busy                     = xfer_active;

endmodule

// File: tb/tb_nvram_backup_ctrl.sv
// Self-checking bench for nvram_backup_ctrl with AUTOSAVE_IDLE=100.
// An HPS model serves restore/backup sectors, an NVRAM model provides port B
// with one-cycle read latency plus a CPU write port, and scoreboard queues
// hold expected NVRAM writes and expected backup bytes.
module tb_nvram_backup_ctrl;

  localparam int IDLE = 100;

  logic        clk30 = 1'b0;
  logic        reset_n;
  logic        img_mounted;
  logic        img_size_nz;
  logic        backup_req;
  logic        sd_rd;
  logic        sd_wr;
  logic [3:0]  sd_lba;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din;
  logic [12:0] nvram_backup_restore_adr;
  logic [7:0]  nvram_restore_data;
  logic        nvram_restore_write;
  logic [7:0]  nvram_backup_data;
  logic        nvram_cpu_changed;
  logic        nvram_allow_cpu_access;
  logic        busy;

  logic        cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_data;

  logic [7:0]  mem  [0:8191];
  logic [7:0]  gold [0:8191];
  logic [20:0] exp_q[$];
  logic [7:0]  din_q[$];

  int n_checks = 0;
  int n_errors = 0;

  nvram_backup_ctrl #(.AUTOSAVE_IDLE(IDLE), .SECTORS(16)) dut (
    .clk30                    (clk30),
    .reset_n                  (reset_n),
    .img_mounted              (img_mounted),
    .img_size_nz              (img_size_nz),
    .backup_req               (backup_req),
    .sd_rd                    (sd_rd),
    .sd_wr                    (sd_wr),
    .sd_lba                   (sd_lba),
    .sd_ack                   (sd_ack),
    .sd_buff_addr             (sd_buff_addr),
    .sd_buff_dout             (sd_buff_dout),
    .sd_buff_wr               (sd_buff_wr),
    .sd_buff_din              (sd_buff_din),
    .nvram_backup_restore_adr (nvram_backup_restore_adr),
    .nvram_restore_data       (nvram_restore_data),
    .nvram_restore_write      (nvram_restore_write),
    .nvram_backup_data        (nvram_backup_data),
    .nvram_cpu_changed        (nvram_cpu_changed),
    .nvram_allow_cpu_access   (nvram_allow_cpu_access),
    .busy                     (busy)
  );

  // ---------------- clock ----------------
  always #5 clk30 = ~clk30;

  // ---------------- NVRAM model ----------------
  assign nvram_cpu_changed = cpu_we;

  always @(posedge clk30) begin
    if (cpu_we) mem[cpu_addr] <= cpu_data;
    if (nvram_restore_write) mem[nvram_backup_restore_adr] <= nvram_restore_data;
    nvram_backup_data <= mem[nvram_backup_restore_adr];
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input logic [12:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // Restore-write scoreboard and request exclusivity monitor.
  always @(negedge clk30) begin
    logic [20:0] e;
    check("rd_wr_exclusive", 32'(sd_rd & sd_wr), 32'd0);
    if (nvram_restore_write) begin
      if (exp_q.size() == 0) begin
        check("restore_write_spurious", 32'(nvram_restore_write), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("restore_write", 32'({nvram_backup_restore_adr, nvram_restore_data}), 32'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk30);
    #1;
  endtask

  task automatic mount(input logic nz);
    tick();
    img_mounted = 1'b1;
    img_size_nz = nz;
    tick();
    img_mounted = 1'b0;
    img_size_nz = 1'b0;
  endtask

  task automatic pulse_backup_req();
    tick();
    backup_req = 1'b1;
    tick();
    backup_req = 1'b0;
  endtask

  task automatic cpu_write(input logic [12:0] a, input logic [7:0] d);
    tick();
    cpu_we   = 1'b1;
    cpu_addr = a;
    cpu_data = d;
    gold[a]  = d;
    tick();
    cpu_we   = 1'b0;
  endtask

  task automatic wait_sector_ack(input int lba, input string tag);
    int n = 0;
    while (!(sd_ack && (sd_lba == 4'(lba))) && n < 20000) begin
      tick();
      n++;
    end
    check(tag, 32'(n < 20000), 32'd1);
  endtask

  task automatic hps_restore_sector(input int lba, input int nbytes, input bit finish);
    int n = 0;
    logic [12:0] a;
    while (!sd_rd && n < 100) begin
      tick();
      n++;
    end
    check("sd_rd_seen", 32'(sd_rd), 32'd1);
    if (!sd_rd) return;
    check("restore_lba", 32'(sd_lba), 32'(lba));
    sd_ack = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      tick();
      if (i == 0) check("sd_rd_drop", 32'(sd_rd), 32'd0);
      a            = {4'(lba), 9'(i)};
      sd_buff_addr = 9'(i);
      sd_buff_dout = pat(a);
      sd_buff_wr   = 1'b1;
      exp_q.push_back({a, pat(a)});
    end
    if (finish) begin
      tick();
      sd_buff_wr = 1'b0;
      sd_ack     = 1'b0;
      check("restore_backlog", 32'(exp_q.size()), 32'd0);
    end
  endtask

  task automatic hps_backup_sector(input int lba);
    int n = 0;
    logic [7:0] e;
    while (!sd_wr && n < 100) begin
      tick();
      n++;
    end
    check("sd_wr_seen", 32'(sd_wr), 32'd1);
    if (!sd_wr) return;
    check("backup_lba", 32'(sd_lba), 32'(lba));
    sd_ack = 1'b1;
    for (int i = 0; i < 512; i++) begin
      tick();
      if (i == 0) begin
        check("sd_wr_drop", 32'(sd_wr), 32'd0);
      end else begin
        e = din_q.pop_front();
        check("backup_byte", 32'(sd_buff_din), 32'(e));
      end
      sd_buff_addr = 9'(i);
      din_q.push_back(gold[{4'(lba), 9'(i)}]);
    end
    tick();
    e = din_q.pop_front();
    check("backup_byte", 32'(sd_buff_din), 32'(e));
    sd_ack = 1'b0;
  endtask

  task automatic restore_all();
    for (int s = 0; s < 16; s++) begin
      hps_restore_sector(s, 512, 1'b1);
      if (s < 15) check("allow_during_restore", 32'(nvram_allow_cpu_access), 32'd0);
    end
    // Last sd_ack fall not yet sampled by the DUT.
    check("allow_before_last_fall", 32'(nvram_allow_cpu_access), 32'd0);
  endtask

  task automatic backup_all();
    for (int s = 0; s < 16; s++) hps_backup_sector(s);
  endtask

  task automatic measure_sd_wr(input string tag, input int exp_n);
    int n = 0;
    while (n < 400) begin
      tick();
      n++;
      if (sd_wr) break;
    end
    check(tag, 32'(n), 32'(exp_n));
  endtask

  task automatic count_sd_wr(input int cycles, input string tag);
    int hits = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (sd_wr || sd_rd) hits++;
    end
    check(tag, 32'(hits), 32'd0);
  endtask

  task automatic check_image(input string tag);
    int bad = 0;
    for (int a = 0; a < 8192; a++) if (mem[a] !== gold[a]) bad++;
    check(tag, 32'(bad), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    repeat (95000) @(posedge clk30);
    $display("FAIL watchdog: cycle budget exhausted, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    reset_n      = 1'b0;
    img_mounted  = 1'b0;
    img_size_nz  = 1'b0;
    backup_req   = 1'b0;
    sd_ack       = 1'b0;
    sd_buff_addr = '0;
    sd_buff_dout = '0;
    sd_buff_wr   = 1'b0;
    cpu_we       = 1'b0;
    cpu_addr     = '0;
    cpu_data     = '0;
    for (int a = 0; a < 8192; a++) gold[a] = pat(13'(a));

    // Reset state
    tick();
    tick();
    check("rst_sd_rd", 32'(sd_rd), 32'd0);
    check("rst_sd_wr", 32'(sd_wr), 32'd0);
    check("rst_allow", 32'(nvram_allow_cpu_access), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_restore_write", 32'(nvram_restore_write), 32'd0);
    check("rst_lba", 32'(sd_lba), 32'd0);
    reset_n = 1'b1;
    count_sd_wr(20, "idle_wait_mount");

    // Empty image: straight to READY, no restore
    mount(1'b0);
    check("empty_allow", 32'(nvram_allow_cpu_access), 32'd1);
    check("empty_busy", 32'(busy), 32'd0);
    count_sd_wr(30, "empty_no_xfer");

    // Restore from a non-empty image; save request and a re-mount arrive mid-restore
    mount(1'b1);
    check("restore_busy", 32'(busy), 32'd1);
    fork
      restore_all();
      begin
        wait_sector_ack(2, "find_sector2");
        pulse_backup_req();
        wait_sector_ack(5, "find_sector5");
        tick();
        img_mounted = 1'b1;
        img_size_nz = 1'b1;
        tick();
        img_mounted = 1'b0;
        img_size_nz = 1'b0;
      end
    join
    tick();
    check("allow_after_restore", 32'(nvram_allow_cpu_access), 32'd1);
    check("ready_sd_wr", 32'(sd_wr), 32'd0);
    check_image("restored_image");
    tick();
    check("pending_backup_start", 32'(sd_wr), 32'd1);
    backup_all();
    tick();
    check("allow_after_backup", 32'(nvram_allow_cpu_access), 32'd1);
    count_sd_wr(150, "clean_no_autosave");

    // Autosave: CPU writes 50 cycles apart, save 100 cycles after the last one
    cpu_write(13'h0123, 8'hC3);
    repeat (48) @(posedge clk30);
    cpu_write(13'h1F00, 8'h3C);
    measure_sd_wr("autosave_delay", IDLE);
    fork
      backup_all();
      begin
        wait_sector_ack(7, "find_wr_sector7");
        cpu_write(13'h1805, 8'hA5);
      end
    join
    tick();
    check("allow_after_autosave", 32'(nvram_allow_cpu_access), 32'd1);
    check("ready_after_autosave", 32'(sd_wr), 32'd0);
    measure_sd_wr("re_autosave_delay", IDLE);
    backup_all();
    tick();
    count_sd_wr(150, "no_third_autosave");

    // Reset in the middle of restore sector 3
    for (int a = 0; a < 8192; a++) gold[a] = pat(13'(a));
    mount(1'b1);
    for (int s = 0; s < 3; s++) hps_restore_sector(s, 512, 1'b1);
    hps_restore_sector(3, 100, 1'b0);
    tick();
    sd_buff_wr = 1'b0;
    reset_n    = 1'b0;
    #1;
    check("abort_sd_rd", 32'(sd_rd), 32'd0);
    check("abort_allow", 32'(nvram_allow_cpu_access), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_restore_write", 32'(nvram_restore_write), 32'd0);
    check("abort_lba", 32'(sd_lba), 32'd0);
    sd_ack = 1'b0;
    exp_q.delete();
    repeat (5) tick();
    reset_n = 1'b1;
    pulse_backup_req();
    count_sd_wr(1000, "no_xfer_after_reset");
    check("allow_after_reset", 32'(nvram_allow_cpu_access), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
